// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, field positions, state encoding.
package fetch_stage_pkg;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam int          BUF_DEPTH        = 2;

  localparam int          OPCODE_MSB = 15;
  localparam int          OPCODE_LSB = 11;
  localparam logic [4:0]  OP_HALT    = 5'b00000;
  localparam logic [4:0]  OP_NOP     = 5'b00001;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HALTED
  } fetchStateT;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } bufEntryT;

  function automatic logic [4:0] opcodeOf(input logic [15:0] inst);
    return inst[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: instruction-memory handshake, decode-side outputs and redirect inputs.
interface fetch_stage_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic [15:0] instruction;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        halted;

  modport master (
    output imem_req, imem_addr, inst_valid, instruction, pc_out, pc_plus2, halted,
    input  imem_ready, imem_rvalid, imem_rdata, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, instruction, pc_out, pc_plus2, halted,
    output imem_ready, imem_rvalid, imem_rdata, stall, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_stage_buf.sv
// 2-entry shift FIFO of {pc, instruction}; slot0 is always the head so outputs come straight from flops.
module fetch_buf
  import fetch_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  bufEntryT pushData,
  input  logic     pop,
  input  logic     flush,
  output bufEntryT head,
  output logic [1:0] count
);

  bufEntryT   slot0;
  bufEntryT   slot1;
  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= pushData;
          else             slot1 <= pushData;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            slot0 <= pushData;
          end else begin
            slot0 <= slot1;
            slot1 <= pushData;
          end
        end
        default: ;
      endcase
    end
  end

  // The request credit rule in the fetch FSM should make this unreachable.
  assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && !flush && cnt == 2'd2));

  assign head  = slot0;
  assign count = cnt;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, one outstanding imem request, 2-entry buffer toward decode.
// HALT detection is built only when FETCH_HALT_DETECT_EN is defined.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master fetchBus
);

  // States: S_FETCH issue request | S_WAIT await response | S_HALTED HALT seen, drain only
  fetchStateT  state, stateNext;
  logic [15:0] pc, pcNext, reqPc;
  logic        dropFlag, dropNext;
  logic        accept, push, pop, flush, haltSeen, reqOut, instValid;
  logic [1:0]  bufCount;
  bufEntryT    headEntry;

  assign accept = reqOut && fetchBus.imem_ready;

`ifdef FETCH_HALT_DETECT_EN
  assign haltSeen        = (opcodeOf(fetchBus.imem_rdata) == OP_HALT);
  assign fetchBus.halted = (state == S_HALTED);
`else
  assign haltSeen        = 1'b0;
  assign fetchBus.halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      reqPc    <= RESET_PC;
      dropFlag <= 1'b0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      dropFlag <= dropNext;
      if (accept) reqPc <= pc;
    end
  end

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    dropNext  = dropFlag;
    case (state)
      S_FETCH: begin
        if (accept) begin
          stateNext = S_WAIT;
          pcNext    = pc + 16'd2;
        end
      end
      S_WAIT: begin
        if (fetchBus.imem_rvalid) begin
          dropNext  = 1'b0;
          stateNext = (!dropFlag && haltSeen) ? S_HALTED : S_FETCH;
        end
      end
      default: ;
    endcase
    // A response landing in the redirect cycle retires the outstanding request, so nothing to drop.
    if (fetchBus.redirect_valid) begin
      pcNext    = fetchBus.redirect_pc & 16'hFFFE;
      dropNext  = accept || (state == S_WAIT && !fetchBus.imem_rvalid);
      stateNext = dropNext ? S_WAIT : S_FETCH;
    end
  end

  always_comb begin
    reqOut = 1'b0;
    push   = 1'b0;
    case (state)
      S_FETCH: reqOut = rst && (int'(bufCount) < BUF_DEPTH);
      S_WAIT:  push   = fetchBus.imem_rvalid && !dropFlag && !fetchBus.redirect_valid;
      default: ;
    endcase
  end

  assign flush     = fetchBus.redirect_valid;
  assign instValid = (bufCount != 2'd0);
  assign pop       = instValid && !fetchBus.stall;

  fetch_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushData ('{pc: reqPc, instr: fetchBus.imem_rdata}),
    .pop      (pop),
    .flush    (flush),
    .head     (headEntry),
    .count    (bufCount)
  );

  assign fetchBus.imem_req    = reqOut;
  assign fetchBus.imem_addr   = pc;
  assign fetchBus.inst_valid  = instValid;
  assign fetchBus.instruction = headEntry.instr;
  assign fetchBus.pc_out      = headEntry.pc;
  assign fetchBus.pc_plus2    = instValid ? headEntry.pc + 16'd2 : 16'h0000;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for linear fetch/stall, hand sequences for redirect, HALT, wrap, reset.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

`ifdef FETCH_HALT_DETECT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if fetchBus ();

  fetch_stage dut (
    .clk      (clk),
    .rst      (rst),
    .fetchBus (fetchBus)
  );

  int errors = 0;
  int checks = 0;

  logic        haltMode = 1'b0;
  logic        holdResp = 1'b0;
  logic        pend;
  logic [15:0] pendAddr;

  function automatic logic [15:0] memData(input logic [15:0] a);
    if (haltMode && a == 16'h0008) return 16'h0000;
    return a ^ 16'h5A5A;
  endfunction

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  // Memory model: request accepted in cycle k is answered in cycle k+1 unless holdResp.
  initial begin
    pend = 1'b0;
    pendAddr = 16'h0000;
    fetchBus.imem_rvalid = 1'b0;
    fetchBus.imem_rdata  = 16'h0000;
    forever begin
      @(posedge clk);
      #2;
      if (pend && !holdResp) begin
        fetchBus.imem_rvalid = 1'b1;
        fetchBus.imem_rdata  = memData(pendAddr);
        pend = 1'b0;
      end else begin
        fetchBus.imem_rvalid = 1'b0;
        fetchBus.imem_rdata  = 16'h0000;
      end
      @(negedge clk);
      if (fetchBus.imem_req && fetchBus.imem_ready) begin
        pend = 1'b1;
        pendAddr = fetchBus.imem_addr;
      end
    end
  end

  // Leaves the bench at the start of cycle 1 (first cycle with rst high).
  task automatic doReset(input logic hm);
    rst = 1'b0;
    fetchBus.stall = 1'b0;
    fetchBus.redirect_valid = 1'b0;
    fetchBus.redirect_pc = 16'h0000;
    fetchBus.imem_ready = 1'b1;
    holdResp = 1'b0;
    haltMode = hm;
    repeat (3) nextCyc();
    @(negedge clk);
    chk1("rst.req", fetchBus.imem_req, 1'b0);
    chk16("rst.addr", fetchBus.imem_addr, 16'h0000);
    chk1("rst.valid", fetchBus.inst_valid, 1'b0);
    chk16("rst.instr", fetchBus.instruction, 16'h0000);
    chk16("rst.pc", fetchBus.pc_out, 16'h0000);
    chk16("rst.pc2", fetchBus.pc_plus2, 16'h0000);
    chk1("rst.halted", fetchBus.halted, 1'b0);
    nextCyc();
    rst = 1'b1;
  endtask

  task automatic waitValid(input string name, input int maxCyc);
    int n = 0;
    @(negedge clk);
    while (!fetchBus.inst_valid && n < maxCyc) begin
      nextCyc();
      @(negedge clk);
      n++;
    end
    chk1(name, fetchBus.inst_valid, 1'b1);
  endtask

  typedef struct {
    logic        stall;
    logic        expReq;
    logic [15:0] expAddr;
    logic        expValid;
    logic [15:0] expPc;
  } vecT;

  vecT vecs [0:16];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 16'h0002, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 16'h0004, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h0002};
    vecs[5]  = '{1'b0, 1'b0, 16'h0006, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 16'h0006, 1'b1, 16'h0004};
    vecs[7]  = '{1'b1, 1'b0, 16'h0008, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h0006};
    vecs[9]  = '{1'b1, 1'b0, 16'h000A, 1'b1, 16'h0006};
    vecs[10] = '{1'b1, 1'b0, 16'h000A, 1'b1, 16'h0006};
    vecs[11] = '{1'b1, 1'b0, 16'h000A, 1'b1, 16'h0006};
    vecs[12] = '{1'b1, 1'b0, 16'h000A, 1'b1, 16'h0006};
    vecs[13] = '{1'b0, 1'b0, 16'h000A, 1'b1, 16'h0006};
    vecs[14] = '{1'b0, 1'b1, 16'h000A, 1'b1, 16'h0008};
    vecs[15] = '{1'b0, 1'b0, 16'h000C, 1'b0, 16'h0000};
    vecs[16] = '{1'b0, 1'b1, 16'h000C, 1'b1, 16'h000A};

    // Linear fetch then a 6-cycle stall that fills the buffer.
    doReset(1'b0);
    for (int i = 0; i < 17; i++) begin
      fetchBus.stall = vecs[i].stall;
      @(negedge clk);
      chk1($sformatf("lin%0d.req", i + 1), fetchBus.imem_req, vecs[i].expReq);
      chk16($sformatf("lin%0d.addr", i + 1), fetchBus.imem_addr, vecs[i].expAddr);
      chk1($sformatf("lin%0d.valid", i + 1), fetchBus.inst_valid, vecs[i].expValid);
      chk1($sformatf("lin%0d.halted", i + 1), fetchBus.halted, 1'b0);
      if (vecs[i].expValid) begin
        chk16($sformatf("lin%0d.pc", i + 1), fetchBus.pc_out, vecs[i].expPc);
        chk16($sformatf("lin%0d.instr", i + 1), fetchBus.instruction, memData(vecs[i].expPc));
        chk16($sformatf("lin%0d.pc2", i + 1), fetchBus.pc_plus2, vecs[i].expPc + 16'd2);
      end
      nextCyc();
    end

    // Redirect to 0041 while the 0006 request is outstanding.
    doReset(1'b0);
    repeat (6) nextCyc();
    fetchBus.stall = 1'b1;
    holdResp = 1'b1;
    @(negedge clk);
    chk1("rdr.c7.req", fetchBus.imem_req, 1'b1);
    chk16("rdr.c7.addr", fetchBus.imem_addr, 16'h0006);
    chk16("rdr.c7.pc", fetchBus.pc_out, 16'h0004);
    nextCyc();
    fetchBus.stall = 1'b0;
    fetchBus.redirect_valid = 1'b1;
    fetchBus.redirect_pc = 16'h0041;
    @(negedge clk);
    chk1("rdr.c8.valid", fetchBus.inst_valid, 1'b1);
    chk1("rdr.c8.req", fetchBus.imem_req, 1'b0);
    nextCyc();
    fetchBus.redirect_valid = 1'b0;
    holdResp = 1'b0;
    @(negedge clk);
    chk1("rdr.c9.valid", fetchBus.inst_valid, 1'b0);
    chk1("rdr.c9.req", fetchBus.imem_req, 1'b0);
    chk16("rdr.c9.addr", fetchBus.imem_addr, 16'h0040);
    nextCyc();
    @(negedge clk);
    chk1("rdr.c10.req", fetchBus.imem_req, 1'b1);
    chk16("rdr.c10.addr", fetchBus.imem_addr, 16'h0040);
    chk1("rdr.c10.valid", fetchBus.inst_valid, 1'b0);
    nextCyc();
    @(negedge clk);
    chk1("rdr.c11.valid", fetchBus.inst_valid, 1'b0);
    nextCyc();
    @(negedge clk);
    chk1("rdr.c12.valid", fetchBus.inst_valid, 1'b1);
    chk16("rdr.c12.pc", fetchBus.pc_out, 16'h0040);
    chk16("rdr.c12.instr", fetchBus.instruction, memData(16'h0040));
    chk16("rdr.c12.pc2", fetchBus.pc_plus2, 16'h0042);
    nextCyc();

    // HALT at 0008 with 0006 still buffered, then redirect to 0020.
    doReset(1'b1);
    repeat (8) nextCyc();
    fetchBus.stall = 1'b1;
    @(negedge clk);
    chk16("hlt.c9.pc", fetchBus.pc_out, 16'h0006);
    chk16("hlt.c9.addr", fetchBus.imem_addr, 16'h0008);
    nextCyc();
    @(negedge clk);
    chk1("hlt.c10.req", fetchBus.imem_req, 1'b0);
    nextCyc();
    fetchBus.stall = 1'b0;
    @(negedge clk);
    chk1("hlt.c11.halted", fetchBus.halted, HALT_EN);
    chk1("hlt.c11.req", fetchBus.imem_req, 1'b0);
    chk16("hlt.c11.pc", fetchBus.pc_out, 16'h0006);
    nextCyc();
    @(negedge clk);
    chk1("hlt.c12.halted", fetchBus.halted, HALT_EN);
    chk1("hlt.c12.req", fetchBus.imem_req, !HALT_EN);
    chk1("hlt.c12.valid", fetchBus.inst_valid, 1'b1);
    chk16("hlt.c12.pc", fetchBus.pc_out, 16'h0008);
    chk16("hlt.c12.instr", fetchBus.instruction, 16'h0000);
    nextCyc();
    @(negedge clk);
    chk1("hlt.c13.halted", fetchBus.halted, HALT_EN);
    chk1("hlt.c13.valid", fetchBus.inst_valid, 1'b0);
    nextCyc();
    fetchBus.redirect_valid = 1'b1;
    fetchBus.redirect_pc = 16'h0020;
    nextCyc();
    fetchBus.redirect_valid = 1'b0;
    @(negedge clk);
    chk1("hlt.c15.halted", fetchBus.halted, 1'b0);
    chk16("hlt.c15.addr", fetchBus.imem_addr, 16'h0020);
    chk1("hlt.c15.valid", fetchBus.inst_valid, 1'b0);
    nextCyc();
    waitValid("hlt.resume.timeout", 10);
    chk16("hlt.resume.pc", fetchBus.pc_out, 16'h0020);
    chk16("hlt.resume.instr", fetchBus.instruction, memData(16'h0020));
    nextCyc();

    // PC wrap from FFFE to 0000.
    doReset(1'b0);
    fetchBus.redirect_valid = 1'b1;
    fetchBus.redirect_pc = 16'hFFFE;
    @(negedge clk);
    chk1("wrap.c1.req", fetchBus.imem_req, 1'b1);
    nextCyc();
    fetchBus.redirect_valid = 1'b0;
    @(negedge clk);
    chk16("wrap.c2.addr", fetchBus.imem_addr, 16'hFFFE);
    chk1("wrap.c2.valid", fetchBus.inst_valid, 1'b0);
    nextCyc();
    @(negedge clk);
    chk1("wrap.c3.req", fetchBus.imem_req, 1'b1);
    chk16("wrap.c3.addr", fetchBus.imem_addr, 16'hFFFE);
    nextCyc();
    @(negedge clk);
    chk16("wrap.c4.addr", fetchBus.imem_addr, 16'h0000);
    nextCyc();
    @(negedge clk);
    chk1("wrap.c5.valid", fetchBus.inst_valid, 1'b1);
    chk16("wrap.c5.pc", fetchBus.pc_out, 16'hFFFE);
    chk16("wrap.c5.pc2", fetchBus.pc_plus2, 16'h0000);
    chk16("wrap.c5.instr", fetchBus.instruction, memData(16'hFFFE));
    nextCyc();

    // Reset during WAIT; the late response must not be buffered.
    doReset(1'b0);
    repeat (2) nextCyc();
    fetchBus.stall = 1'b1;
    holdResp = 1'b1;
    @(negedge clk);
    chk16("mrst.c3.pc", fetchBus.pc_out, 16'h0000);
    chk16("mrst.c3.addr", fetchBus.imem_addr, 16'h0002);
    nextCyc();
    rst = 1'b0;
    @(negedge clk);
    chk1("mrst.c4.req", fetchBus.imem_req, 1'b0);
    nextCyc();
    rst = 1'b1;
    holdResp = 1'b0;
    fetchBus.stall = 1'b0;
    @(negedge clk);
    chk1("mrst.c5.req", fetchBus.imem_req, 1'b1);
    chk16("mrst.c5.addr", fetchBus.imem_addr, 16'h0000);
    chk1("mrst.c5.valid", fetchBus.inst_valid, 1'b0);
    chk16("mrst.c5.instr", fetchBus.instruction, 16'h0000);
    chk16("mrst.c5.pc", fetchBus.pc_out, 16'h0000);
    chk16("mrst.c5.pc2", fetchBus.pc_plus2, 16'h0000);
    nextCyc();
    @(negedge clk);
    chk1("mrst.c6.valid", fetchBus.inst_valid, 1'b0);
    nextCyc();
    @(negedge clk);
    chk1("mrst.c7.valid", fetchBus.inst_valid, 1'b1);
    chk16("mrst.c7.pc", fetchBus.pc_out, 16'h0000);
    chk16("mrst.c7.instr", fetchBus.instruction, memData(16'h0000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
